// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Adder.sv
// Existing 1-bit full adder cell driven by the serial adder sequencer.
module Full_Adder (
    input  logic D1,
    input  logic D2,
    input  logic Cin,
    output logic Sout,
    output logic Cout
);

    assign Sout = D1 ^ D2 ^ Cin;
    assign Cout = (D1 & D2) | (D1 & Cin) | (D2 & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one Full_Adder plus a carry flip-flop, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement overflow output ovf_out.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf_out,
`endif
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [CW-1:0]    count;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic             accept;

    assign accept = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (count == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    Full_Adder u_fa (
        .D1   (a_sr[0]),
        .D2   (b_sr[0]),
        .Cin  (carry),
        .Sout (fa_s),
        .Cout (fa_c)
    );

    // Operands shift right so bit 0 always feeds the cell; sum fills from the MSB end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= c_in;
            count <= '0;
        end else if (state == S_RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_c;
            count  <= count + 1'b1;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf;

    // On the MSB step the carry FF still holds the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (state == S_RUN && count == LAST) begin
            ovf <= carry ^ fa_c;
        end
    end

    assign ovf_out = ovf;
`endif

    assign sum_out = sum_sr;
    assign c_out   = carry;

endmodule
